// File: rtl/immediate_encoder.sv
// Iterative encoder for the 12-bit shift-operand field: searches the ARM rotated-immediate
// form one rotation per cycle, or checks the 12-bit sign-extended memory-offset form.
module immediate_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] value,
    input  logic        memoryInstruction,
    output logic        outValid,
    input  logic        outReady,
    output logic        encodable,
    output logic [11:0] shiftOperand,
    output logic [3:0]  rotateImmediate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] cap_value;
    logic        cap_mem;
    logic [3:0]  rot;

    logic [4:0]  shamt;
    logic [31:0] candidate;
    logic        rot_hit;
    logic        mem_hit;
    logic        search_done;
    logic        res_enc;
    logic [11:0] res_so;
    logic [3:0]  res_ri;

    // Rotating left by 2r undoes the encoding's rotate-right; a zero-distance rotate
    // shifts the wrapped half out entirely, so no special case is needed.
    always_comb begin
        shamt     = {rot, 1'b0};
        candidate = (cap_value << shamt) | (cap_value >> (6'd32 - {1'b0, shamt}));
        rot_hit   = (candidate[31:8] == 24'd0);
        mem_hit   = (&cap_value[31:11]) | ~(|cap_value[31:11]);
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        res_enc = 1'b0;
        res_so  = 12'h000;
        res_ri  = 4'd0;
        if (cap_mem) begin
            res_enc = mem_hit;
            res_so  = mem_hit ? cap_value[11:0] : 12'h000;
        end else if (rot_hit) begin
            res_enc = 1'b1;
            res_so  = {rot, candidate[7:0]};
            res_ri  = rot;
        end
    end

    assign search_done = cap_mem || rot_hit || (rot == 4'd15);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (inValid) state_next = SEARCH;
            SEARCH:  if (search_done) state_next = DONE;
            DONE:    if (outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cap_value       <= 32'd0;
            cap_mem         <= 1'b0;
            rot             <= 4'd0;
            encodable       <= 1'b0;
            shiftOperand    <= 12'h000;
            rotateImmediate <= 4'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && inValid) begin
                cap_value <= value;
                cap_mem   <= memoryInstruction;
                rot       <= 4'd0;
            end else if (state == SEARCH) begin
                if (search_done) begin
                    encodable       <= res_enc;
                    shiftOperand    <= res_so;
                    rotateImmediate <= res_ri;
                end else begin
                    rot <= rot + 4'd1;
                end
            end
        end
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed bench for immediate_encoder: expected results queued at stimulus time,
// popped and compared when outValid appears, including latency and backpressure checks.
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] value;
    logic        memoryInstruction;
    logic        outValid;
    logic        outReady;
    logic        encodable;
    logic [11:0] shiftOperand;
    logic [3:0]  rotateImmediate;

    typedef struct {
        logic        enc;
        logic [11:0] so;
        logic [3:0]  ri;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    immediate_encoder dut (
        .clk               (clk),
        .rst               (rst),
        .inValid           (inValid),
        .inReady           (inReady),
        .value             (value),
        .memoryInstruction (memoryInstruction),
        .outValid          (outValid),
        .outReady          (outReady),
        .encodable         (encodable),
        .shiftOperand      (shiftOperand),
        .rotateImmediate   (rotateImmediate)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Queue the expectation, hand the request over, scramble the inputs right after
    // acceptance, then wait (bounded) for the result and compare it with the queue head.
    task automatic send(input string tag, input logic [31:0] v, input logic m,
                        input logic e, input logic [11:0] so, input logic [3:0] ri,
                        input int lat);
        exp_t x;
        exp_t got;
        int   n;
        x.enc = e; x.so = so; x.ri = ri; x.lat = lat;
        sb.push_back(x);
        n = 0;
        while (!inReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, {31'd0, inReady}, 32'd1);
        inValid           = 1'b1;
        value             = v;
        memoryInstruction = m;
        @(posedge clk);
        @(negedge clk);
        inValid           = 1'b0;
        value             = $urandom;
        memoryInstruction = ~m;
        n = 0;
        while (!outValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, {31'd0, outValid}, 32'd1);
        if (outValid && sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_latency"},  n,                      got.lat);
            check({tag, "_enc"},      {31'd0, encodable},     {31'd0, got.enc});
            check({tag, "_shift_op"}, {20'd0, shiftOperand},  {20'd0, got.so});
            check({tag, "_rot_imm"},  {28'd0, rotateImmediate}, {28'd0, got.ri});
        end
    endtask

    task automatic take(input string tag);
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        check({tag, "_ready_after_take"}, {31'd0, inReady},  32'd1);
        check({tag, "_valid_after_take"}, {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst               = 1'b0;
        inValid           = 1'b0;
        value             = 32'd0;
        memoryInstruction = 1'b0;
        outReady          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, inReady},         32'd1);
        check("rst_out_valid", {31'd0, outValid},        32'd0);
        check("rst_enc",       {31'd0, encodable},       32'd0);
        check("rst_shift_op",  {20'd0, shiftOperand},    32'd0);
        check("rst_rot_imm",   {28'd0, rotateImmediate}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send("rot_ff", 32'h0000_00FF, 1'b0, 1'b1, 12'h0FF, 4'd0, 1);
        take("rot_ff");
        send("rot_zero", 32'h0000_0000, 1'b0, 1'b1, 12'h000, 4'd0, 1);
        take("rot_zero");
        send("rot_wrap", 32'hF000_000F, 1'b0, 1'b1, 12'h2FF, 4'd2, 3);
        take("rot_wrap");
        send("rot_r15", 32'h0000_0104, 1'b0, 1'b1, 12'hF41, 4'd15, 16);
        take("rot_r15");
        send("rot_none", 32'h0000_0101, 1'b0, 1'b0, 12'h000, 4'd0, 16);
        take("rot_none");
        send("mem_neg", 32'hFFFF_F800, 1'b1, 1'b1, 12'h800, 4'd0, 1);
        take("mem_neg");
        send("mem_pos", 32'h0000_07FF, 1'b1, 1'b1, 12'h7FF, 4'd0, 1);
        take("mem_pos");
        send("mem_bad", 32'h0000_0800, 1'b1, 1'b0, 12'h000, 4'd0, 1);
        take("mem_bad");

        send("rot_ff000000", 32'hFF00_0000, 1'b0, 1'b1, 12'h4FF, 4'd4, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, outValid},        32'd1);
            check("bp_in_ready",  {31'd0, inReady},         32'd0);
            check("bp_shift_op",  {20'd0, shiftOperand},    32'h4FF);
            check("bp_enc",       {31'd0, encodable},       32'd1);
            check("bp_rot_imm",   {28'd0, rotateImmediate}, 32'd4);
        end
        take("bp");

        // Reset lands on E3 of an unencodable search; nothing must ever come out.
        inValid           = 1'b1;
        value             = 32'h0000_0101;
        memoryInstruction = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready",  {31'd0, inReady},      32'd1);
        check("mid_rst_out_valid", {31'd0, outValid},     32'd0);
        check("mid_rst_enc",       {31'd0, encodable},    32'd0);
        check("mid_rst_shift_op",  {20'd0, shiftOperand}, 32'd0);
        rst  = 1'b1;
        seen = 0;
        repeat (24) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        check("mid_rst_no_output", seen, 0);

        send("post_rst", 32'h0000_3FC0, 1'b0, 1'b1, 12'hDFF, 4'd13, 14);
        take("post_rst");

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
